divide8_signed_sequential: RTL and testbench
============================================

Name: divide8_signed_sequential

Overview:
Sequential signed divider, the inverse of the team's 8x8 signed structural multiplier. Divides a 2*WIDTH-bit two's-complement dividend by a WIDTH-bit divisor. Produces a WIDTH-bit quotient and a WIDTH-bit remainder using restoring division, one bit per clock. A start/busy/done handshake allows a product from the multiplier to be fed back and checked.

Parameters:
WIDTH, 8, divisor/quotient/remainder width; dividend is 2*WIDTH bits

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
dividend_a  input  2*WIDTH  signed dividend; captured on the accepted start
divisor_b  input  WIDTH  signed divisor; captured on the accepted start
busy  output  1  high from the edge after start is accepted until done
done  output  1  one-cycle pulse; results valid
quotient  output  WIDTH  signed quotient, truncated toward zero
remainder  output  WIDTH  signed remainder; takes the sign of the dividend
overflow  output  1  quotient not representable in WIDTH signed bits
div_by_zero  output  1  divisor_b was 0

Behaviour:
- Reset (async, any state, including mid-operation):
  - State returns to IDLE.
  - busy, done, quotient, remainder, overflow and div_by_zero all go to 0.
  - Any in-flight operation is discarded.
- States: IDLE, CALC, FIX.
- IDLE:
  - On a clk edge with start=1, latch the operand signs.
  - Latch |dividend_a| as a 2*WIDTH-bit unsigned value and |divisor_b| as a WIDTH-bit unsigned value (|-128| = 128).
  - Clear the iteration counter to 0, set busy=1, go to CALC.
- Error precheck, made at acceptance and stored:
  - div0 = (divisor_b == 0).
  - uovf = (|a|[2W-1:W] >= |b|) and not div0.
- CALC, one iteration per edge, WIDTH edges total:
  - Shift the partial remainder left 1 and bring in the next dividend bit.
  - If the partial remainder >= |b|, subtract |b| and the quotient bit is 1; otherwise the quotient bit is 0.
  - Counter wraps at WIDTH-1; after that iteration go to FIX.
- FIX, single edge:
  - Apply signs: quotient is negated when the operand signs differ; remainder is negated when the dividend is negative.
  - Signed range check: overflow=1 if uovf, or if the magnitude > 2^(W-1)-1 with equal signs, or if the magnitude > 2^(W-1) with differing signs.
  - If div0 or overflow: quotient=0, remainder=0; div_by_zero=div0; overflow set as computed (0 when div0).
  - Set done=1 and busy=0; return to IDLE.
- Latency:
  - done is high for exactly one cycle after the (WIDTH+1)th edge following the accepting edge (9 cycles for WIDTH=8).
  - Latency is deterministic, including error cases (without the macro).
- Output hold: quotient, remainder and the flags hold their values until the next FIX or reset.
- start while busy is ignored (no queueing). start held high in IDLE on the same cycle done is high launches a new operation.
- Operand inputs may change freely after the accepting edge.
- Arithmetic: all internal magnitudes are unsigned, with one extra bit in the partial remainder to avoid compare overflow. No sign extension happens in the CALC datapath.

Optional Feature:
DIVIDE_SIGNED_EARLY_ERR_EN
- Defined: when div0 or uovf is detected at acceptance, CALC is skipped and the block goes directly IDLE -> FIX. done then pulses after the 1st edge following acceptance, with outputs and flags as specified above. Valid divisions still take WIDTH+1 edges.
- Undefined: every operation, error or not, takes WIDTH+1 edges. CALC runs on magnitudes, and its result is discarded in FIX.

Test Plan:
- 100/7: dividend_a=16'h0064, divisor_b=8'h07, start for 1 cycle -> busy high; done exactly 9 cycles later; quotient=8'h0E, remainder=8'h02, overflow=0, div_by_zero=0.
- -100/7: 16'hFF9C by 8'h07 -> quotient=8'hF2 (-14), remainder=8'hFE (-2). Also 16'h0064 by 8'hF9 (-7) -> quotient=8'hF2, remainder=8'h02.
- Multiplier round-trip edges:
  - 16'h4000 / 8'h80 -> quotient=8'h80, remainder=0, overflow=0.
  - 16'h3F01 / 8'h7F -> quotient=8'h7F, remainder=0.
  - 16'h4000 / 8'h7F -> overflow=1, quotient=0, remainder=0.
- Overflow and div0:
  - 16'h8000 / 8'hFF -> overflow=1, quotient=0.
  - 16'h1234 / 8'h00 -> div_by_zero=1, overflow=0, quotient=0, remainder=0.
  - Without the macro, done comes at cycle 9; with DIVIDE_SIGNED_EARLY_ERR_EN, at cycle 1 while the 100/7 case stays at 9.
- Handshake:
  - Pulse start again 3 cycles into an operation with new operands -> ignored; original result unchanged.
  - start held high through done -> a second operation begins in the done cycle, and its done follows 9 cycles later.
- Reset mid-CALC: assert rst asynchronously between edges at iteration 4 -> all outputs 0 immediately, no done pulse. A subsequent 100/7 completes correctly.

Source files
------------

// File: rtl/divide8_signed_sequential_if.sv
// Divider handshake bundle: start/operands toward the divider, busy/done/results back.
// master drives requests, slave is the divider side.
interface divide8_signed_sequential_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic [2*WIDTH-1:0]   dividend_a;
  logic [WIDTH-1:0]     divisor_b;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     quotient;
  logic [WIDTH-1:0]     remainder;
  logic                 overflow;
  logic                 div_by_zero;

  modport master (
    output start, dividend_a, divisor_b,
    input  busy, done, quotient, remainder, overflow, div_by_zero
  );

  modport slave (
    input  start, dividend_a, divisor_b,
    output busy, done, quotient, remainder, overflow, div_by_zero
  );
endinterface

// File: rtl/divide8_signed_sequential.sv
// Signed restoring divider (2W/W -> W quotient, W remainder), one quotient bit per clock.
// done pulses WIDTH+1 edges after acceptance; start ignored while busy. DIVIDE_SIGNED_EARLY_ERR_EN: errors finish after 1 edge.
module divide8_signed_sequential #(
  parameter int WIDTH = 8
) (
  input logic                         clk,
  input logic                         rst,
  divide8_signed_sequential_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               sa_q, sa_d, sb_q, sb_d, div0_q, div0_d, uovf_q, uovf_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0]   quot_q, quot_d, remo_q, remo_d;
  logic               ovf_q, ovf_d, dz_q, dz_d;

  logic [2*WIDTH-1:0] a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     trial;
  logic               ge, q_neg, range_ovf;

  // Magnitudes are unsigned, so |most negative| still fits.
  assign a_mag = bus.dividend_a[2*WIDTH-1] ? -bus.dividend_a : bus.dividend_a;
  assign b_mag = bus.divisor_b[WIDTH-1]    ? -bus.divisor_b  : bus.divisor_b;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lo_d      = lo_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    div0_d    = div0_q;
    uovf_d    = uovf_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    quot_d    = quot_q;
    remo_d    = remo_q;
    ovf_d     = ovf_q;
    dz_d      = dz_q;
    trial     = {rem_q[WIDTH-1:0], lo_q[WIDTH-1]};
    ge        = trial >= {1'b0, dvs_q};
    q_neg     = sa_q ^ sb_q;
    range_ovf = uovf_q | (!q_neg && (quo_q > MAX_POS)) | (q_neg && (quo_q > MAX_NEG));

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sa_d    = bus.dividend_a[2*WIDTH-1];
          sb_d    = bus.divisor_b[WIDTH-1];
          // Upper half seeds the partial remainder; uovf guarantees the quotient fits W bits otherwise.
          rem_d   = {1'b0, a_mag[2*WIDTH-1:WIDTH]};
          lo_d    = a_mag[WIDTH-1:0];
          dvs_d   = b_mag;
          div0_d  = (bus.divisor_b == '0);
          uovf_d  = (a_mag[2*WIDTH-1:WIDTH] >= b_mag) && (bus.divisor_b != '0);
          quo_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CALC;
`ifdef DIVIDE_SIGNED_EARLY_ERR_EN
          if (div0_d || uovf_d) state_d = FIX;
`endif
        end
      end
      CALC: begin
        rem_d = ge ? (trial - {1'b0, dvs_q}) : trial;
        quo_d = {quo_q[WIDTH-2:0], ge};
        lo_d  = {lo_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = FIX;
        end
      end
      FIX: begin
        if (div0_q) begin
          quot_d = '0;
          remo_d = '0;
          ovf_d  = 1'b0;
          dz_d   = 1'b1;
        end else if (range_ovf) begin
          quot_d = '0;
          remo_d = '0;
          ovf_d  = 1'b1;
          dz_d   = 1'b0;
        end else begin
          quot_d = q_neg ? -quo_q : quo_q;
          remo_d = sa_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
          ovf_d  = 1'b0;
          dz_d   = 1'b0;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lo_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      div0_q  <= 1'b0;
      uovf_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      div0_q  <= div0_d;
      uovf_q  <= uovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = remo_q;
  assign bus.overflow    = ovf_q;
  assign bus.div_by_zero = dz_q;
endmodule

// File: tb/tb_divide8_signed_sequential.sv
// Scoreboard bench: stimulus pushes reference results, a negedge monitor pops on done.
module tb_divide8_signed_sequential;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  divide8_signed_sequential_if #(.WIDTH(W)) bus ();
  divide8_signed_sequential #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       ovf;
    logic       dz;
    int         acc;
    int         lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain signed integer division, truncating toward zero.
  function automatic exp_t model(input logic [15:0] a, input logic [7:0] b, input int acc);
    exp_t e;
    int sa, sd, qi, ri, ma, mb;
    sa = int'($signed(a));
    sd = int'($signed(b));
    e.q = 8'h00; e.r = 8'h00; e.ovf = 1'b0; e.dz = (sd == 0);
    e.acc = acc; e.lat = 9;
    ma = (sa < 0) ? -sa : sa;
    mb = (sd < 0) ? -sd : sd;
    if (!e.dz) begin
      qi = sa / sd;
      ri = sa % sd;
      if (qi > 127 || qi < -128) e.ovf = 1'b1;
      else begin
        e.q = 8'(qi);
        e.r = 8'(ri);
      end
    end
`ifdef DIVIDE_SIGNED_EARLY_ERR_EN
    if (e.dz || (ma >= 256 * mb)) e.lat = 1;
`else
    if (ma < 0) e.lat = 0;
`endif
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=1 with no operation outstanding (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("quotient",     32'(bus.quotient),    32'(mon_e.q));
        chk("remainder",    32'(bus.remainder),   32'(mon_e.r));
        chk("overflow",     32'(bus.overflow),    32'(mon_e.ovf));
        chk("div_by_zero",  32'(bus.div_by_zero), 32'(mon_e.dz));
        chk("latency",      32'(cyc - mon_e.acc), 32'(mon_e.lat));
        chk("busy_at_done", 32'(bus.busy),        32'd0);
      end
    end
  end

  // Raise start, wait for the accepting edge, push the expected result.
  task automatic issue(input logic [15:0] a, input logic [7:0] b, input bit hold, output int acc);
    @(posedge clk);
    #1;
    bus.start      = 1'b1;
    bus.dividend_a = a;
    bus.divisor_b  = b;
    @(posedge clk);
    #1;
    acc = cyc;
    sb.push_back(model(a, b, acc));
    chk("busy_after_accept", 32'(bus.busy), 32'd1);
    if (!hold) bus.start = 1'b0;
    bus.dividend_a = 16'($urandom);
    bus.divisor_b  = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run(input logic [15:0] a, input logic [7:0] b);
    int acc;
    issue(a, b, 1'b0, acc);
    wait_idle();
  endtask

  initial begin
    int acc;
    logic [15:0] dir_a [10] = '{16'h0064, 16'hFF9C, 16'h0064, 16'h4000, 16'h3F01,
                                16'h4000, 16'h8000, 16'h1234, 16'h8000, 16'h0064};
    logic [7:0]  dir_b [10] = '{8'h07, 8'h07, 8'hF9, 8'h80, 8'h7F,
                                8'h7F, 8'hFF, 8'h00, 8'h80, 8'h07};

    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.dividend_a = '0;
    bus.divisor_b  = '0;
    #12;
    chk("rst_busy",  32'(bus.busy),        32'd0);
    chk("rst_done",  32'(bus.done),        32'd0);
    chk("rst_quot",  32'(bus.quotient),    32'd0);
    chk("rst_rem",   32'(bus.remainder),   32'd0);
    chk("rst_ovf",   32'(bus.overflow),    32'd0);
    chk("rst_dz",    32'(bus.div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run(dir_a[i], dir_b[i]);

    // start pulsed mid-operation must be ignored
    issue(16'h0064, 8'h07, 1'b0, acc);
    repeat (2) @(posedge clk);
    #1;
    bus.start      = 1'b1;
    bus.dividend_a = 16'h1234;
    bus.divisor_b  = 8'h05;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_idle();

    // start held through done launches a second operation in the done cycle
    issue(16'h0064, 8'h07, 1'b1, acc);
    bus.dividend_a = 16'hFF9C;
    bus.divisor_b  = 8'h07;
    sb.push_back(model(16'hFF9C, 8'h07, acc + 10));
    repeat (10) @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("busy_second_op", 32'(bus.busy), 32'd1);
    wait_idle();

    // async reset during CALC discards the operation
    issue(16'h0064, 8'h07, 1'b0, acc);
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    sb.delete();
    chk("midrst_busy", 32'(bus.busy),        32'd0);
    chk("midrst_done", 32'(bus.done),        32'd0);
    chk("midrst_quot", 32'(bus.quotient),    32'd0);
    chk("midrst_rem",  32'(bus.remainder),   32'd0);
    chk("midrst_ovf",  32'(bus.overflow),    32'd0);
    chk("midrst_dz",   32'(bus.div_by_zero), 32'd0);
    #3;
    rst = 1'b0;
    repeat (12) @(posedge clk);
    run(16'h0064, 8'h07);

    // random mix: fully random operands and products built to stay in range
    for (int i = 0; i < 40; i++) begin
      logic [15:0] a;
      logic [7:0]  b;
      int qv, bv, rv;
      if (i % 2 == 0) begin
        a = 16'($urandom);
        b = 8'($urandom);
      end else begin
        bv = int'($urandom_range(0, 255)) - 128;
        if (bv == 0) bv = 3;
        qv = int'($urandom_range(0, 255)) - 128;
        rv = int'($urandom_range(0, ((bv < 0) ? -bv : bv) - 1));
        if (qv * bv < 0) rv = -rv;
        a = 16'(qv * bv + rv);
        b = 8'(bv);
      end
      run(a, b);
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
